// File: rtl/branch_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve                                                             |
// | Execute-stage branch resolution: mispredict redirect plus a small FIFO     |
// | of BTB training writes drained one per cycle, with saturating statistics.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef XLEN
`define XLEN 32
`endif

module branch_resolve #(
   parameter int UPDQ_DEPTH = 4,
   parameter int CNT_W      = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               ex_valid,
   input  logic [`XLEN-1:0]   ex_pc,
   input  logic               ex_is_branch,
   input  logic               ex_is_jump,
   input  logic               ex_taken,
   input  logic [`XLEN-1:0]   ex_target,
   input  logic               ex_pred_hit,
   input  logic [`XLEN-1:0]   ex_pred_target,
   input  logic               btb_upd_ready,
   output logic               redirect_valid,
   output logic [`XLEN-1:0]   redirect_pc,
   output logic               update_enable,
   output logic [`XLEN-1:0]   pc_update,
   output logic [`XLEN-1:0]   target_update,
   output logic               is_branch_or_jump,
   output logic [CNT_W-1:0]   br_count,
   output logic [CNT_W-1:0]   mispred_count,
   output logic [CNT_W-1:0]   drop_count
);

   localparam int PTR_W = (UPDQ_DEPTH > 1) ? $clog2(UPDQ_DEPTH) : 1;
   localparam int CW    = PTR_W + 1;

   localparam logic [`XLEN-1:0] c_pc_step = `XLEN'(4);
   localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
   localparam logic [CW-1:0]    c_cnt_one = CW'(1);
   localparam logic [CW-1:0]    c_full    = CW'(UPDQ_DEPTH);
   localparam logic [CNT_W-1:0] c_stat_one = CNT_W'(1);

   // Resolution datapath
   logic               w_cf;
   logic [`XLEN-1:0]   w_seq;
   logic [`XLEN-1:0]   w_pred_next;
   logic [`XLEN-1:0]   w_actual_next;
   logic               w_mispredict;
   logic               w_enq_req;

   // FIFO control
   logic               w_deq;
   logic               w_full;
   logic               w_enq;
   logic               w_drop;

   logic [`XLEN-1:0]   r_pc_q  [UPDQ_DEPTH];
   logic [`XLEN-1:0]   r_tgt_q [UPDQ_DEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CW-1:0]      r_count;

   logic               r_redirect_valid;
   logic [`XLEN-1:0]   r_redirect_pc;
   logic [CNT_W-1:0]   r_br_count;
   logic [CNT_W-1:0]   r_mispred_count;
   logic [CNT_W-1:0]   r_drop_count;

   always_comb begin
      w_cf          = ex_is_branch | ex_is_jump;
      w_seq         = ex_pc + c_pc_step;
      w_pred_next   = ex_pred_hit ? ex_pred_target : w_seq;
      w_actual_next = (w_cf & ex_taken) ? ex_target : w_seq;
      w_mispredict  = ex_valid & (w_pred_next != w_actual_next);
      // Only taken control flow trains; a non-cf alias cannot be invalidated.
      w_enq_req     = ex_valid & w_cf & ex_taken &
                      (~ex_pred_hit | (ex_pred_target != ex_target));
   end

   always_comb begin
      w_deq  = (r_count != '0) & btb_upd_ready;
      w_full = (r_count == c_full);
      w_enq  = w_enq_req & (~w_full | w_deq);
      w_drop = w_enq_req & w_full & ~w_deq;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < UPDQ_DEPTH; i++) begin
            r_pc_q[i]  <= '0;
            r_tgt_q[i] <= '0;
         end
      end else if (w_enq) begin
         r_pc_q[r_wr_ptr]  <= ex_pc;
         r_tgt_q[r_wr_ptr] <= ex_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_redirect_valid <= w_mispredict;
         r_redirect_pc    <= w_mispredict ? w_actual_next : '0;
      end
   end

   // Statistics counters hold at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_br_count      <= '0;
         r_mispred_count <= '0;
         r_drop_count    <= '0;
      end else begin
         if ((ex_valid & w_cf) && (r_br_count != '1)) begin
            r_br_count <= r_br_count + c_stat_one;
         end
         if (w_mispredict && (r_mispred_count != '1)) begin
            r_mispred_count <= r_mispred_count + c_stat_one;
         end
         if (w_drop && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + c_stat_one;
         end
      end
   end

   always_comb begin
      update_enable     = w_deq;
      is_branch_or_jump = w_deq;
      pc_update         = w_deq ? r_pc_q[r_rd_ptr]  : '0;
      target_update     = w_deq ? r_tgt_q[r_rd_ptr] : '0;
   end

   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign br_count       = r_br_count;
   assign mispred_count  = r_mispred_count;
   assign drop_count     = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_resolve                                                          |
// | Directed and random stimulus against a queue-based reference model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef XLEN
`define XLEN 32
`endif

module tb_branch_resolve;

   localparam int DEPTH = 4;
   localparam int CNT_W = 32;
   localparam int XW    = `XLEN;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_hit;
   logic [XW-1:0]    ex_pc, ex_target, ex_pred_target;
   logic             btb_upd_ready;
   logic             redirect_valid, update_enable, is_branch_or_jump;
   logic [XW-1:0]    redirect_pc, pc_update, target_update;
   logic [CNT_W-1:0] br_count, mispred_count, drop_count;

   always #5 clk = ~clk;

   branch_resolve #(.UPDQ_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .ex_valid          (ex_valid),
      .ex_pc             (ex_pc),
      .ex_is_branch      (ex_is_branch),
      .ex_is_jump        (ex_is_jump),
      .ex_taken          (ex_taken),
      .ex_target         (ex_target),
      .ex_pred_hit       (ex_pred_hit),
      .ex_pred_target    (ex_pred_target),
      .btb_upd_ready     (btb_upd_ready),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .update_enable     (update_enable),
      .pc_update         (pc_update),
      .target_update     (target_update),
      .is_branch_or_jump (is_branch_or_jump),
      .br_count          (br_count),
      .mispred_count     (mispred_count),
      .drop_count        (drop_count)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: pending training writes as {pc, target} in arrival order.
   logic [2*XW-1:0]  m_q[$];
   logic [CNT_W-1:0] m_br, m_mis, m_drop;
   logic             m_rv;
   logic [XW-1:0]    m_rpc;
   bit               m_known = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + CNT_W'(1);
   endfunction

   task automatic drive(input logic v, input logic br, input logic jp, input logic tk,
                        input logic [XW-1:0] pc, input logic [XW-1:0] tgt,
                        input logic hit, input logic [XW-1:0] pt, input logic rdy);
      ex_valid       = v;
      ex_is_branch   = br;
      ex_is_jump     = jp;
      ex_taken       = tk;
      ex_pc          = pc;
      ex_target      = tgt;
      ex_pred_hit    = hit;
      ex_pred_target = pt;
      btb_upd_ready  = rdy;
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, rdy);
   endtask

   // Check the model against the DUT, then advance both through one rising edge.
   task automatic step();
      logic          cf, mis, enq, deq;
      logic [XW-1:0] seq, pn, an;
      int            sz;
      #1;
      if (m_known) begin
         deq = (m_q.size() != 0) && btb_upd_ready;
         chk("update_enable", update_enable, deq);
         chk("is_branch_or_jump", is_branch_or_jump, deq);
         chk("pc_update", pc_update, deq ? m_q[0][2*XW-1:XW] : '0);
         chk("target_update", target_update, deq ? m_q[0][XW-1:0] : '0);
         chk("redirect_valid", redirect_valid, m_rv);
         chk("redirect_pc", redirect_pc, m_rpc);
         chk("br_count", br_count, m_br);
         chk("mispred_count", mispred_count, m_mis);
         chk("drop_count", drop_count, m_drop);
      end
      @(posedge clk);
      if (!reset_n) begin
         m_q.delete();
         m_br = '0; m_mis = '0; m_drop = '0; m_rv = 1'b0; m_rpc = '0;
         m_known = 1;
      end else if (m_known) begin
         cf  = ex_is_branch | ex_is_jump;
         seq = ex_pc + XW'(4);
         pn  = ex_pred_hit ? ex_pred_target : seq;
         an  = (cf && ex_taken) ? ex_target : seq;
         mis = ex_valid && (pn != an);
         enq = ex_valid && cf && ex_taken && (!ex_pred_hit || ex_pred_target != ex_target);
         sz  = m_q.size();
         deq = (sz != 0) && btb_upd_ready;
         if (deq) void'(m_q.pop_front());
         if (enq) begin
            if (sz == DEPTH && !deq) m_drop = sat(m_drop);
            else m_q.push_back({ex_pc, ex_target});
         end
         if (ex_valid && cf) m_br = sat(m_br);
         if (mis) m_mis = sat(m_mis);
         m_rv  = mis;
         m_rpc = mis ? an : '0;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [XW-1:0] pc, tgt, pt;
      logic          v, br, jp, tk, hit, rdy;

      reset_n = 1'b0;
      idle(1'b0);
      @(negedge clk);
      step();
      reset_n = 1'b1;
      #1;
      chk("rst_update_enable", update_enable, 1'b0);
      chk("rst_redirect_valid", redirect_valid, 1'b0);
      chk("rst_redirect_pc", redirect_pc, '0);
      chk("rst_br_count", br_count, '0);
      chk("rst_mispred_count", mispred_count, '0);
      chk("rst_drop_count", drop_count, '0);
      step();

      // Taken branch with no BTB hit
      drive(1, 1, 0, 1, 32'h100, 32'h200, 0, 32'h0, 1);
      step();
      chk("miss_redirect_valid", redirect_valid, 1'b1);
      chk("miss_redirect_pc", redirect_pc, 32'h200);
      chk("miss_update_enable", update_enable, 1'b1);
      chk("miss_pc_update", pc_update, 32'h100);
      chk("miss_target_update", target_update, 32'h200);
      chk("miss_mispred_count", mispred_count, 32'd1);
      chk("miss_br_count", br_count, 32'd1);

      // Correctly predicted
      drive(1, 1, 0, 1, 32'h100, 32'h200, 1, 32'h200, 1);
      step();
      chk("hit_redirect_valid", redirect_valid, 1'b0);
      chk("hit_update_enable", update_enable, 1'b0);
      chk("hit_br_count", br_count, 32'd2);
      chk("hit_mispred_count", mispred_count, 32'd1);

      // Not-taken branch that was predicted taken
      drive(1, 1, 0, 0, 32'h100, 32'h200, 1, 32'h200, 1);
      step();
      chk("nt_redirect_valid", redirect_valid, 1'b1);
      chk("nt_redirect_pc", redirect_pc, 32'h104);
      chk("nt_update_enable", update_enable, 1'b0);

      // Non-cf alias at the top of the address space
      drive(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 1, 32'h500, 1);
      step();
      chk("alias_redirect_valid", redirect_valid, 1'b1);
      chk("alias_redirect_pc", redirect_pc, 32'h0);
      chk("alias_update_enable", update_enable, 1'b0);
      chk("alias_br_count", br_count, 32'd3);
      chk("alias_mispred_count", mispred_count, 32'd3);

      // Overflow: five training events against a stalled BTB
      for (int i = 1; i <= 5; i++) begin
         drive(1, 1, 0, 1, XW'(32'h10 * i), XW'(32'h1000 + 32'h10 * i), 0, '0, 0);
         step();
      end
      chk("ovf_drop_count", drop_count, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         idle(1'b1);
         #1;
         chk("ovf_update_enable", update_enable, 1'b1);
         chk("ovf_order", pc_update, XW'(32'h10 * i));
         step();
      end
      idle(1'b1);
      #1;
      chk("ovf_drained", update_enable, 1'b0);
      step();

      // Full FIFO with simultaneous enqueue and dequeue
      for (int i = 6; i <= 9; i++) begin
         drive(1, 0, 1, 1, XW'(32'h10 * i), XW'(32'h2000 + 32'h10 * i), 0, '0, 0);
         step();
      end
      drive(1, 0, 1, 1, 32'hA0, 32'h20A0, 0, '0, 1);
      step();
      chk("full_no_drop", drop_count, 32'd1);
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         #1;
         chk("full_order", pc_update, XW'(32'h70 + 32'h10 * i));
         step();
      end
      idle(1'b1);
      #1;
      chk("full_drained", update_enable, 1'b0);
      step();

      // Reset with queued entries and a pending redirect
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 1, XW'(32'hB0 + 32'h10 * i), XW'(32'h3000 + 32'h10 * i), 0, '0, 0);
         step();
      end
      chk("pre_rst_redirect", redirect_valid, 1'b1);
      reset_n = 1'b0;
      idle(1'b1);
      step();
      reset_n = 1'b1;
      #1;
      chk("mid_rst_update_enable", update_enable, 1'b0);
      chk("mid_rst_pc_update", pc_update, '0);
      chk("mid_rst_redirect_valid", redirect_valid, 1'b0);
      chk("mid_rst_redirect_pc", redirect_pc, '0);
      chk("mid_rst_br_count", br_count, '0);
      chk("mid_rst_drop_count", drop_count, '0);
      for (int i = 0; i < 3; i++) step();

      // Random traffic over a small PC pool so predictions often coincide
      for (int n = 0; n < 400; n++) begin
         v   = ($urandom_range(0, 3) != 0);
         br  = ($urandom_range(0, 1) == 1);
         jp  = !br && ($urandom_range(0, 2) == 0);
         tk  = jp ? 1'b1 : ($urandom_range(0, 1) == 1);
         pc  = XW'(32'h1000 + 4 * $urandom_range(0, 7));
         pc  = ($urandom_range(0, 31) == 0) ? XW'(32'hFFFF_FFFC) : pc;
         tgt = XW'(32'h4000 + 4 * $urandom_range(0, 3));
         hit = ($urandom_range(0, 1) == 1);
         pt  = ($urandom_range(0, 1) == 1) ? tgt : XW'(32'h4000 + 4 * $urandom_range(0, 3));
         rdy = ($urandom_range(0, 9) < 6);
         reset_n = ($urandom_range(0, 99) != 0);
         drive(v, br, jp, tk, pc, tgt, hit, pt, rdy);
         step();
      end
      reset_n = 1'b1;
      idle(1'b1);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
